// File: rtl/edge_event_pkg.sv
// Shared types and defaults for the edge event unit.
// Holds the block state enum, default parameter values and a width helper.
// Imported by edge_event_unit and edge_filter_ch.
package edge_event_pkg;

  typedef enum logic {
    PRIME = 1'b0,
    RUN   = 1'b1
  } state_e;

  localparam int DEF_WIDTH       = 8;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_DEBOUNCE    = 0;
  localparam int DEF_CNT_W       = 16;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int width_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/edge_filter_ch.sv
// One input channel: synchroniser chain, debounce filter and edge pulse registers.
// Ports: clk_i/rst_i, prime_i (block still priming), signal_i (raw async input),
//        rise_nxt_o/fall_nxt_o (edge being accepted this cycle), rise_o/fall_o (registered pulses).
module edge_filter_ch
  import edge_event_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int DEBOUNCE    = DEF_DEBOUNCE
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic prime_i,
  input  logic signal_i,
  output logic rise_nxt_o,
  output logic fall_nxt_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int DW = width_min1(DEBOUNCE + 1);
  localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   filt_q, filt_d;
  logic [DW-1:0]          cnt_q, cnt_d;
  logic                   rise_q, fall_q;
  logic                   synced, synced_nxt;

  assign synced     = sync_q[SYNC_STAGES-1];
  // Value the last stage will hold after this edge.
  assign synced_nxt = sync_q[SYNC_STAGES-2];

  always_comb begin
    filt_d = filt_q;
    cnt_d  = cnt_q;
    if (prime_i) begin
      // Track what synced is about to become, so filt equals synced on the
      // first RUN cycle and a level held through reset yields no edge.
      filt_d = synced_nxt;
      cnt_d  = '0;
    end else if (synced == filt_q) begin
      cnt_d = '0;
    end else if (cnt_q == DB_MAX) begin
      filt_d = synced;
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign rise_nxt_o = ~prime_i &  filt_d & ~filt_q;
  assign fall_nxt_o = ~prime_i & ~filt_d &  filt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
      filt_q <= 1'b0;
      cnt_q  <= '0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], signal_i};
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
      rise_q <= rise_nxt_o;
      fall_q <= fall_nxt_o;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/edge_event_unit.sv
// Multi-channel edge detector with per-channel pending flags, irq and saturating event counter.
// Ports: CLK/RST, signal (raw inputs), rise_en/fall_en (event enables), clr (pending clear),
//        cnt_clr; outputs pos_edge/neg_edge pulses, pending, irq, evt_count, ready.
module edge_event_unit
  import edge_event_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int DEBOUNCE    = DEF_DEBOUNCE,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] signal,
  input  logic [WIDTH-1:0] rise_en,
  input  logic [WIDTH-1:0] fall_en,
  input  logic [WIDTH-1:0] clr,
  input  logic             cnt_clr,
  output logic [WIDTH-1:0] pos_edge,
  output logic [WIDTH-1:0] neg_edge,
  output logic [WIDTH-1:0] pending,
  output logic             irq,
  output logic [CNT_W-1:0] evt_count,
  output logic             ready
);

  localparam int PW  = width_min1(SYNC_STAGES + 1);
  localparam int PCW = width_min1(WIDTH + 1);
  localparam int SW  = CNT_W + PCW;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e            state_q, state_d;
  logic [PW-1:0]     prime_cnt_q, prime_cnt_d;
  logic              prime;
  logic [WIDTH-1:0]  rise_nxt, fall_nxt, evt;
  logic [WIDTH-1:0]  pending_q, pending_d;
  logic              irq_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PCW-1:0]    evt_pop;
  logic [SW-1:0]     cnt_sum;

  // Priming: stay in PRIME for exactly SYNC_STAGES edges, then RUN forever.
  always_comb begin
    state_d     = state_q;
    prime_cnt_d = prime_cnt_q;
    case (state_q)
      PRIME: begin
        prime_cnt_d = prime_cnt_q + 1'b1;
        if (prime_cnt_q == PW'(SYNC_STAGES - 1)) state_d = RUN;
      end
      RUN:     state_d = RUN;
      default: state_d = PRIME;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= PRIME;
      prime_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      prime_cnt_q <= prime_cnt_d;
    end
  end

  assign prime = (state_q == PRIME);
  assign ready = (state_q == RUN);

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    edge_filter_ch #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEBOUNCE   (DEBOUNCE)
    ) u_ch (
      .clk_i     (CLK),
      .rst_i     (RST),
      .prime_i   (prime),
      .signal_i  (signal[i]),
      .rise_nxt_o(rise_nxt[i]),
      .fall_nxt_o(fall_nxt[i]),
      .rise_o    (pos_edge[i]),
      .fall_o    (neg_edge[i])
    );
  end

  // Events use the same-edge acceptance so pending/count update with the pulse.
  assign evt       = (rise_nxt & rise_en) | (fall_nxt & fall_en);
  assign pending_d = (pending_q & ~clr) | evt;

  always_comb begin
    evt_pop = '0;
    for (int i = 0; i < WIDTH; i++) evt_pop = evt_pop + PCW'(evt[i]);
  end

  // Wide sum so the saturation compare sees the true total.
  assign cnt_sum = (cnt_clr ? '0 : SW'(cnt_q)) + SW'(evt_pop);
  assign cnt_d   = (cnt_sum > SW'(CNT_MAX)) ? CNT_MAX : cnt_sum[CNT_W-1:0];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pending_q <= '0;
      irq_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      pending_q <= pending_d;
      irq_q     <= |pending_q;
      cnt_q     <= cnt_d;
    end
  end

  assign pending   = pending_q;
  assign irq       = irq_q;
  assign evt_count = cnt_q;

endmodule

// File: tb/tb_edge_event_unit.sv
module tb_edge_event_unit;
  localparam int W = 8;

  typedef struct {
    int           at;
    logic [W-1:0] pos;
    logic [W-1:0] neg;
  } exp_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  // Instance A: default parameters
  logic [W-1:0] a_sig = '0, a_ren = '0, a_fen = '0, a_clr = '0;
  logic         a_cclr = 1'b0;
  logic [W-1:0] a_pos, a_neg, a_pend;
  logic         a_irq, a_rdy;
  logic [15:0]  a_cnt;

  // Instance B: DEBOUNCE=3, CNT_W=4
  logic [W-1:0] b_sig = '0, b_ren = '0, b_fen = '0, b_clr = '0;
  logic         b_cclr = 1'b0;
  logic [W-1:0] b_pos, b_neg, b_pend;
  logic         b_irq, b_rdy;
  logic [3:0]   b_cnt;

  edge_event_unit #(.WIDTH(W)) u_a (
    .CLK(CLK), .RST(RST), .signal(a_sig), .rise_en(a_ren), .fall_en(a_fen),
    .clr(a_clr), .cnt_clr(a_cclr), .pos_edge(a_pos), .neg_edge(a_neg),
    .pending(a_pend), .irq(a_irq), .evt_count(a_cnt), .ready(a_rdy)
  );

  edge_event_unit #(.WIDTH(W), .DEBOUNCE(3), .CNT_W(4)) u_b (
    .CLK(CLK), .RST(RST), .signal(b_sig), .rise_en(b_ren), .fall_en(b_fen),
    .clr(b_clr), .cnt_clr(b_cclr), .pos_edge(b_pos), .neg_edge(b_neg),
    .pending(b_pend), .irq(b_irq), .evt_count(b_cnt), .ready(b_rdy)
  );

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  exp_t qa[$];
  exp_t qb[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Input driven now is first sampled at edge cyc+1; pulse appears after
  // edge cyc+1+SYNC_STAGES+DEBOUNCE.
  task automatic drive_a(input logic [W-1:0] nv);
    exp_t e;
    e.at  = cyc + 1 + 2;
    e.pos = nv & ~a_sig;
    e.neg = ~nv & a_sig;
    if ((e.pos | e.neg) != '0) qa.push_back(e);
    a_sig = nv;
  endtask

  task automatic drive_b(input logic [W-1:0] nv, input bit push);
    exp_t e;
    e.at  = cyc + 1 + 2 + 3;
    e.pos = nv & ~b_sig;
    e.neg = ~nv & b_sig;
    if (push && ((e.pos | e.neg) != '0)) qb.push_back(e);
    b_sig = nv;
  endtask

  // Pulse monitors: every observed pulse must match the queue head.
  always @(negedge CLK) begin
    exp_t e;
    if (!RST) begin
      if (qa.size() > 0 && qa[0].at < cyc) begin
        chk("a_missed_pulse", 64'(cyc), 64'(qa[0].at));
        void'(qa.pop_front());
      end
      if ((a_pos | a_neg) != '0) begin
        if (qa.size() == 0) chk("a_unexpected_pulse", {a_pos, a_neg}, 64'd0);
        else begin
          e = qa.pop_front();
          chk("a_pulse_time", 64'(cyc), 64'(e.at));
          chk("a_pulse_vec", {a_pos, a_neg}, {e.pos, e.neg});
        end
      end
    end
  end

  always @(negedge CLK) begin
    exp_t e;
    if (!RST) begin
      if (qb.size() > 0 && qb[0].at < cyc) begin
        chk("b_missed_pulse", 64'(cyc), 64'(qb[0].at));
        void'(qb.pop_front());
      end
      if ((b_pos | b_neg) != '0) begin
        if (qb.size() == 0) chk("b_unexpected_pulse", {b_pos, b_neg}, 64'd0);
        else begin
          e = qb.pop_front();
          chk("b_pulse_time", 64'(cyc), 64'(e.at));
          chk("b_pulse_vec", {b_pos, b_neg}, {e.pos, e.neg});
        end
      end
    end
  end

  initial begin
    // Reset with channel 0 of A held high through release
    a_sig = 8'h01;
    tick(3);
    chk("rst_a_outs", {a_pos, a_neg, a_pend, 7'd0, a_irq, a_cnt}, 64'd0);
    chk("rst_a_ready", 64'(a_rdy), 64'd0);
    chk("rst_b_outs", {b_pos, b_neg, b_pend, 3'd0, b_irq, b_cnt}, 64'd0);
    RST = 1'b0;
    tick(1);
    chk("prime_a_edge1", 64'(a_rdy), 64'd0);
    chk("prime_b_edge1", 64'(b_rdy), 64'd0);
    tick(1);
    chk("ready_a_edge2", 64'(a_rdy), 64'd1);
    chk("ready_b_edge2", 64'(b_rdy), 64'd1);
    tick(5);
    chk("held_high_pending", 64'(a_pend), 64'd0);

    // A: rise enabled, fall disabled on channel 1
    a_ren = 8'hFF;
    a_fen = 8'h00;
    drive_a(8'h03);
    tick(3);
    chk("a_pend_on_rise", 64'(a_pend), 64'h02);
    chk("a_cnt_rise", 64'(a_cnt), 64'd1);
    chk("a_irq_lag", 64'(a_irq), 64'd0);
    tick(1);
    chk("a_irq_set", 64'(a_irq), 64'd1);
    drive_a(8'h01);
    tick(4);
    chk("a_cnt_fall_masked", 64'(a_cnt), 64'd1);
    chk("a_pend_once", 64'(a_pend), 64'h02);

    // Clear, then clear coinciding with a new enabled event
    a_clr = 8'h02;
    tick(1);
    a_clr = 8'h00;
    chk("a_clr_pending", 64'(a_pend), 64'h00);
    tick(1);
    chk("a_irq_cleared", 64'(a_irq), 64'd0);
    drive_a(8'h03);
    tick(2);
    a_clr = 8'h02;
    tick(1);
    a_clr = 8'h00;
    chk("a_set_beats_clr", 64'(a_pend), 64'h02);
    chk("a_cnt_second", 64'(a_cnt), 64'd2);
    a_fen = 8'h02;
    drive_a(8'h01);
    tick(4);
    chk("a_cnt_fall_en", 64'(a_cnt), 64'd3);

    // B: debounce glitch of 3 cycles is filtered, steady rise is accepted
    drive_b(8'h04, 1'b0);
    tick(3);
    drive_b(8'h00, 1'b0);
    tick(10);
    drive_b(8'h04, 1'b1);
    tick(8);
    chk("b_no_count_masked", 64'(b_cnt), 64'd0);
    drive_b(8'h00, 1'b1);
    tick(8);

    // B: 4-bit counter saturation and cnt_clr with coincident events
    b_ren = 8'hFF;
    drive_b(8'hFF, 1'b1);
    tick(6);
    chk("b_cnt_8", 64'(b_cnt), 64'd8);
    drive_b(8'h00, 1'b1);
    tick(8);
    drive_b(8'hFF, 1'b1);
    tick(6);
    chk("b_cnt_sat", 64'(b_cnt), 64'd15);
    drive_b(8'h00, 1'b1);
    tick(8);
    drive_b(8'h07, 1'b1);
    tick(5);
    b_cclr = 1'b1;
    tick(1);
    b_cclr = 1'b0;
    chk("b_cnt_clr_evt", 64'(b_cnt), 64'd3);
    b_cclr = 1'b1;
    tick(1);
    b_cclr = 1'b0;
    chk("b_cnt_clr", 64'(b_cnt), 64'd0);

    // B: reset at debounce count 2 of 3
    drive_b(8'h00, 1'b0);
    tick(4);
    RST = 1'b1;
    qb.delete();
    tick(1);
    chk("mid_rst_b_outs", {b_pos, b_neg, b_pend, 3'd0, b_irq, b_cnt}, 64'd0);
    chk("mid_rst_b_ready", 64'(b_rdy), 64'd0);
    RST = 1'b0;
    tick(1);
    chk("reprime_b_edge1", 64'(b_rdy), 64'd0);
    tick(1);
    chk("reprime_b_edge2", 64'(b_rdy), 64'd1);
    tick(12);
    chk("post_rst_b_pend", 64'(b_pend), 64'd0);
    chk("post_rst_a_pend", 64'(a_pend), 64'd0);

    chk("a_queue_drained", 64'(qa.size()), 64'd0);
    chk("b_queue_drained", 64'(qb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
